// File: rtl/bram_uart_feeder_pkg.sv
// Shared constants for the BRAM-to-UART feeder and the BRAM wrapper around it.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bram_uart_feeder_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int LEN_W_DEF  = 11;
    localparam int RD_LAT_DEF = 1;

    // Cycles to wait for tx_busy to rise before assuming the byte was taken.
    localparam int ACK_TMO    = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_READ      = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_REQ       = 3'd3,
        ST_WAIT_HI   = 3'd4,
        ST_WAIT_LO   = 3'd5,
        ST_FINISH    = 3'd6
    } state_t;

endpackage

// File: rtl/bram_uart_feeder_rd_lat_pipe.sv
// Tracks an outstanding BRAM read and flags the cycle its data is on bram_dout.
// Latency: cap_vld follows rd_vld by exactly RD_LAT cycles.
// Backpressure: none; one bit per cycle, never stalls.
module bram_uart_feeder_rd_lat_pipe
    import bram_uart_feeder_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic CLK_50M,
    input  logic rst_n,
    input  logic rd_vld,
    output logic cap_vld
);

    logic [RD_LAT-1:0] vld_sr;

    // Shift the read-enable down an RD_LAT-deep valid line.
    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= rd_vld;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

    assign cap_vld = vld_sr[RD_LAT-1];

endmodule

// File: rtl/bram_uart_feeder.sv
// Reads len bytes from BRAM starting at start_addr and hands each to the UART TX.
// Latency: start at edge T -> bram_en in T+1, first tx_req in T+2+RD_LAT.
// Backpressure: each read waits for tx_busy low; one byte in flight at a time.
module bram_uart_feeder
    import bram_uart_feeder_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              CLK_50M,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [7:0]        bram_dout,
    output logic              tx_req,
    output logic [7:0]        tx_din,
    input  logic              tx_busy,
    output logic              active,
    output logic              done,
    output logic [LEN_W-1:0]  sent_cnt
);

    state_t            state;
    logic [LEN_W-1:0]  remaining;
    logic [1:0]        ack_tmo_cnt;
    logic              cap_vld;

    bram_uart_feeder_rd_lat_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_lat_pipe (
        .CLK_50M (CLK_50M),
        .rst_n   (rst_n),
        .rd_vld  (bram_en),
        .cap_vld (cap_vld)
    );

    // Feeder FSM; all outputs registered. bram_en is raised on the edge that
    // enters READ when tx_busy is already low, so the read lands one cycle
    // after start or after the busy fall.
    always_ff @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            bram_en     <= 1'b0;
            bram_addr   <= '0;
            tx_req      <= 1'b0;
            tx_din      <= '0;
            active      <= 1'b0;
            done        <= 1'b0;
            sent_cnt    <= '0;
            remaining   <= '0;
            ack_tmo_cnt <= '0;
        end else begin
            bram_en <= 1'b0;
            tx_req  <= 1'b0;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bram_addr <= start_addr;
                        remaining <= len;
                        sent_cnt  <= '0;
                        active    <= 1'b1;
                        if (len == '0) begin
                            done  <= 1'b1;
                            state <= ST_FINISH;
                        end else begin
                            bram_en <= !tx_busy;
                            state   <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    // Read issued this cycle moves on; otherwise wait for TX idle.
                    if (bram_en) begin
                        state <= ST_WAIT_DATA;
                    end else if (!tx_busy) begin
                        bram_en <= 1'b1;
                    end
                end
                ST_WAIT_DATA: begin
                    if (cap_vld) begin
                        tx_din <= bram_dout;
                        tx_req <= 1'b1;
                        state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    sent_cnt    <= sent_cnt + LEN_W'(1);
                    remaining   <= remaining - LEN_W'(1);
                    bram_addr   <= bram_addr + ADDR_W'(1);
                    ack_tmo_cnt <= '0;
                    state       <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    // A TX that never raises busy is treated as having taken the byte.
                    if (tx_busy || ack_tmo_cnt == 2'(ACK_TMO - 1)) begin
                        state <= ST_WAIT_LO;
                    end else begin
                        ack_tmo_cnt <= ack_tmo_cnt + 2'd1;
                    end
                end
                ST_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (remaining == '0 || abort) begin
                            done  <= 1'b1;
                            state <= ST_FINISH;
                        end else begin
                            bram_en <= 1'b1;
                            state   <= ST_READ;
                        end
                    end
                end
                ST_FINISH: begin
                    active <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_uart_feeder.sv
// Directed bench for bram_uart_feeder: RD_LAT=1 and RD_LAT=2 instances on a shared BRAM image.
// Latency: n/a.
// Backpressure: TX model holds busy for busy_len cycles after each tx_req (0 = never busy).
module tb_bram_uart_feeder;
    import bram_uart_feeder_pkg::*;

    logic CLK_50M = 1'b0;
    always #10 CLK_50M = ~CLK_50M;

    logic        rst_n;
    logic        start, abort;
    logic [9:0]  start_addr;
    logic [10:0] len;
    logic        bram_en;
    logic [9:0]  bram_addr;
    logic [7:0]  bram_dout;
    logic        tx_req;
    logic [7:0]  tx_din;
    logic        tx_busy;
    logic        active, done;
    logic [10:0] sent_cnt;

    logic        start2, abort2;
    logic [9:0]  start_addr2;
    logic [10:0] len2;
    logic        bram_en2;
    logic [9:0]  bram_addr2;
    logic [7:0]  bram_dout2;
    logic        tx_req2;
    logic [7:0]  tx_din2;
    logic        tx_busy2;
    logic        active2, done2;
    logic [10:0] sent_cnt2;

    logic [7:0]  mem [0:1023];
    logic [7:0]  rd2_s1;
    int          busy_len = 20;
    int          busy_cnt;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    logic [9:0]  en_addr_q [$];
    int          en_cyc_q [$];
    logic [7:0]  req_dat_q [$];
    int          req_cyc_q [$];
    int          done_cyc_q [$];
    logic [7:0]  req2_dat_q [$];
    int          req2_cyc_q [$];
    int          done2_cyc_q [$];
    int          viol_en_busy, viol_req_busy, viol_req_b2b;
    logic        req_prev = 1'b0;
    logic [7:0]  exp_dat [4];
    int          t0;

    bram_uart_feeder #(.ADDR_W(10), .LEN_W(11), .RD_LAT(1)) dut1 (
        .CLK_50M(CLK_50M), .rst_n(rst_n), .start(start), .abort(abort),
        .start_addr(start_addr), .len(len), .bram_en(bram_en), .bram_addr(bram_addr),
        .bram_dout(bram_dout), .tx_req(tx_req), .tx_din(tx_din), .tx_busy(tx_busy),
        .active(active), .done(done), .sent_cnt(sent_cnt)
    );

    bram_uart_feeder #(.ADDR_W(10), .LEN_W(11), .RD_LAT(2)) dut2 (
        .CLK_50M(CLK_50M), .rst_n(rst_n), .start(start2), .abort(abort2),
        .start_addr(start_addr2), .len(len2), .bram_en(bram_en2), .bram_addr(bram_addr2),
        .bram_dout(bram_dout2), .tx_req(tx_req2), .tx_din(tx_din2), .tx_busy(tx_busy2),
        .active(active2), .done(done2), .sent_cnt(sent_cnt2)
    );

    always @(posedge CLK_50M) cyc <= cyc + 1;

    // BRAM: one-cycle port for dut1, two-cycle port for dut2.
    always @(posedge CLK_50M) begin
        if (bram_en)  bram_dout <= mem[bram_addr];
        if (bram_en2) rd2_s1    <= mem[bram_addr2];
        bram_dout2 <= rd2_s1;
    end

    // UART TX model for dut1; dut2's TX never reports busy.
    always @(posedge CLK_50M or negedge rst_n) begin
        if (!rst_n)                       busy_cnt <= 0;
        else if (tx_req && busy_len != 0) busy_cnt <= busy_len;
        else if (busy_cnt != 0)           busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy  = (busy_cnt != 0);
    assign tx_busy2 = 1'b0;

    // Event log, sampled mid-cycle.
    always @(negedge CLK_50M) begin
        if (bram_en) begin
            en_addr_q.push_back(bram_addr);
            en_cyc_q.push_back(cyc);
            if (tx_busy) viol_en_busy++;
        end
        if (tx_req) begin
            req_dat_q.push_back(tx_din);
            req_cyc_q.push_back(cyc);
            if (tx_busy)  viol_req_busy++;
            if (req_prev) viol_req_b2b++;
        end
        req_prev = tx_req;
        if (done) done_cyc_q.push_back(cyc);
        if (tx_req2) begin
            req2_dat_q.push_back(tx_din2);
            req2_cyc_q.push_back(cyc);
        end
        if (done2) done2_cyc_q.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic launch(input bit which, input logic [9:0] a, input logic [10:0] l, output int t_start);
        @(negedge CLK_50M);
        en_addr_q.delete(); en_cyc_q.delete(); req_dat_q.delete(); req_cyc_q.delete();
        done_cyc_q.delete(); req2_dat_q.delete(); req2_cyc_q.delete(); done2_cyc_q.delete();
        viol_en_busy = 0; viol_req_busy = 0; viol_req_b2b = 0;
        if (which) begin
            start_addr2 = a; len2 = l; start2 = 1'b1;
        end else begin
            start_addr = a; len = l; start = 1'b1;
        end
        t_start = cyc;
        @(negedge CLK_50M);
        start = 1'b0; start2 = 1'b0;
    endtask

    task automatic wait_done(input bit which, input string tag, input int budget);
        int k = 0;
        while ((which ? done2_cyc_q.size() : done_cyc_q.size()) == 0 && k < budget) begin
            @(negedge CLK_50M); #1;
            k++;
        end
        check(tag, (which ? done2_cyc_q.size() : done_cyc_q.size()) != 0, 1);
    endtask

    task automatic wait_reqs(input int n, input int budget);
        int k = 0;
        while (req_dat_q.size() < n && k < budget) begin
            @(negedge CLK_50M); #1;
            k++;
        end
        check("wait_reqs", req_dat_q.size() >= n, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; start_addr = '0; len = '0;
        start2 = 1'b0; abort2 = 1'b0; start_addr2 = '0; len2 = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 7 + 3);
        mem[10'h010] = 8'h55; mem[10'h011] = 8'hAA; mem[10'h012] = 8'h0F; mem[10'h013] = 8'hF0;
        mem[10'h3FE] = 8'h11; mem[10'h3FF] = 8'h22; mem[10'h000] = 8'h33;
        mem[10'h020] = 8'hC3; mem[10'h021] = 8'h3C;
        exp_dat[0] = 8'h55; exp_dat[1] = 8'hAA; exp_dat[2] = 8'h0F; exp_dat[3] = 8'hF0;

        // Reset state
        repeat (3) @(negedge CLK_50M);
        check("rst_ctl", {bram_en, tx_req, active, done}, 0);
        check("rst_addr", bram_addr, 0);
        check("rst_din", tx_din, 0);
        check("rst_cnt", sent_cnt, 0);
        check("rst_state", 32'(dut1.state), 32'(ST_IDLE));
        rst_n = 1'b1;
        repeat (2) @(negedge CLK_50M);

        // Four bytes, 20-cycle busy
        busy_len = 20;
        launch(0, 10'h010, 11'd4, t0);
        wait_done(0, "t1_done", 300);
        check("t1_done_act", {active, done}, 2'b11);
        @(negedge CLK_50M); #1;
        check("t1_after_done", {active, done}, 2'b00);
        repeat (3) @(negedge CLK_50M);
        check("t1_nreq", req_dat_q.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("t1_dat%0d", i), req_dat_q[i], exp_dat[i]);
        check("t1_en_lat", en_cyc_q[0], t0 + 1);
        check("t1_req_lat", req_cyc_q[0], t0 + 3);
        check("t1_req_gap", req_cyc_q[1] - req_cyc_q[0], 24);
        check("t1_en_gap", en_cyc_q[1] - req_cyc_q[0], 22);
        check("t1_done_cyc", done_cyc_q[0], req_cyc_q[3] + 22);
        check("t1_ndone", done_cyc_q.size(), 1);
        check("t1_last_addr", en_addr_q[3], 10'h013);
        check("t1_sent", sent_cnt, 4);
        check("t1_en_busy", viol_en_busy, 0);
        check("t1_req_busy", viol_req_busy, 0);
        check("t1_req_b2b", viol_req_b2b, 0);

        // Address wrap
        busy_len = 5;
        launch(0, 10'h3FE, 11'd3, t0);
        wait_done(0, "t2_done", 200);
        repeat (2) @(negedge CLK_50M);
        check("t2_addr0", en_addr_q[0], 10'h3FE);
        check("t2_addr1", en_addr_q[1], 10'h3FF);
        check("t2_addr2", en_addr_q[2], 10'h000);
        check("t2_nreq", req_dat_q.size(), 3);
        check("t2_dat2", req_dat_q[2], 8'h33);
        check("t2_sent", sent_cnt, 3);

        // Zero length
        launch(0, 10'h050, 11'd0, t0);
        wait_done(0, "t3_done", 10);
        repeat (3) @(negedge CLK_50M);
        check("t3_done_cyc", done_cyc_q[0], t0 + 1);
        check("t3_nen", en_addr_q.size(), 0);
        check("t3_nreq", req_dat_q.size(), 0);
        check("t3_sent", sent_cnt, 0);

        // Abort during byte 3
        busy_len = 20;
        launch(0, 10'h100, 11'd10, t0);
        wait_reqs(3, 200);
        abort = 1'b1;
        wait_done(0, "t4_done", 100);
        abort = 1'b0;
        repeat (30) @(negedge CLK_50M);
        check("t4_nreq", req_dat_q.size(), 3);
        check("t4_sent", sent_cnt, 3);
        check("t4_dat2", req_dat_q[2], mem[10'h102]);
        check("t4_done_cyc", done_cyc_q[0], req_cyc_q[2] + 22);
        check("t4_active", active, 0);

        // Restart ignored while active, then reset in WAIT_LO
        launch(0, 10'h010, 11'd4, t0);
        @(negedge CLK_50M);
        start_addr = 10'h200; len = 11'd1; start = 1'b1;
        @(negedge CLK_50M);
        start = 1'b0;
        wait_reqs(1, 50);
        repeat (8) @(negedge CLK_50M);
        check("t5_nen", en_addr_q.size(), 1);
        check("t5_addr", en_addr_q[0], 10'h010);
        check("t5_sent_pre", sent_cnt, 1);
        check("t5_state_pre", 32'(dut1.state), 32'(ST_WAIT_LO));
        rst_n = 1'b0;
        #1;
        check("t5_rst_ctl", {bram_en, tx_req, active, done}, 0);
        check("t5_rst_addr", bram_addr, 0);
        check("t5_rst_din", tx_din, 0);
        check("t5_rst_cnt", sent_cnt, 0);
        check("t5_rst_state", 32'(dut1.state), 32'(ST_IDLE));
        @(negedge CLK_50M);
        rst_n = 1'b1;
        repeat (5) @(negedge CLK_50M);
        check("t5_no_done", done_cyc_q.size(), 0);
        launch(0, 10'h012, 11'd2, t0);
        wait_done(0, "t5_done", 150);
        repeat (2) @(negedge CLK_50M);
        check("t5_nreq", req_dat_q.size(), 2);
        check("t5_dat0", req_dat_q[0], 8'h0F);
        check("t5_dat1", req_dat_q[1], 8'hF0);
        check("t5_sent", sent_cnt, 2);

        // RD_LAT=2, TX never busy
        launch(1, 10'h020, 11'd2, t0);
        wait_done(1, "t6_done", 100);
        repeat (2) @(negedge CLK_50M);
        check("t6_nreq", req2_dat_q.size(), 2);
        check("t6_dat0", req2_dat_q[0], 8'hC3);
        check("t6_dat1", req2_dat_q[1], 8'h3C);
        check("t6_req0_cyc", req2_cyc_q[0], t0 + 4);
        check("t6_req1_cyc", req2_cyc_q[1], t0 + 13);
        check("t6_done_cyc", done2_cyc_q[0], t0 + 19);
        check("t6_sent", sent_cnt2, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
